// File: rtl/alu_op_sequencer_if.sv
// Handshake and result bundle between the ALU sequencer and its consumer.
// The slave side is the sequencer; the master side issues operations.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [1:0]             op;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   ready;
    logic                   valid;
    logic [2*WIDTH-1:0]     res_add;
    logic [2*WIDTH-1:0]     res_sub;
    logic [2*WIDTH-1:0]     res_mul;
    logic [2*WIDTH-1:0]     res_div;
    logic [3:0]             sel;
    logic                   dbz;

    modport master (
        output start, op, a, b,
        input  ready, valid, res_add, res_sub, res_mul, res_div, sel, dbz
    );

    modport slave (
        input  start, op, a, b,
        output ready, valid, res_add, res_sub, res_mul, res_div, sel, dbz
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALU front-end sequencer: single-cycle add/sub, iterative mul/div,
// registered candidate results and one-hot select for the result mux.
module alu_op_sequencer #(
    parameter int WIDTH = 8,
    parameter int ITER  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_op_sequencer_if.slave bus
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(ITER) + 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    state_t            state;
    logic [1:0]        op_q;
    logic [CW-1:0]     cnt;
    logic [RW-1:0]     prod;
    logic [RW-1:0]     mcand;
    logic [WIDTH-1:0]  mplier;
    logic [WIDTH-1:0]  rem;
    logic [WIDTH-1:0]  quo;
    logic [WIDTH-1:0]  divisor;

    logic [WIDTH:0]    sum;
    logic [WIDTH:0]    diff;
    logic [3:0]        sel_dec;
    logic [RW-1:0]     prod_next;
    logic [WIDTH:0]    trial;
    logic [WIDTH-1:0]  rem_next;
    logic [WIDTH-1:0]  quo_next;
    logic              last;

    always_comb begin
        sum       = {1'b0, bus.a} + {1'b0, bus.b};
        diff      = {1'b0, bus.a} - {1'b0, bus.b};
        sel_dec   = 4'b0001 << bus.op;
        prod_next = mplier[0] ? prod + mcand : prod;
        // Restoring step: the partial remainder stays below divisor,
        // so the subtracted value always fits back into WIDTH bits.
        trial     = {rem, quo[WIDTH-1]};
        rem_next  = trial[WIDTH-1:0];
        quo_next  = {quo[WIDTH-2:0], 1'b0};
        if (trial >= {1'b0, divisor}) begin
            rem_next = trial[WIDTH-1:0] - divisor;
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
        last = (cnt == CW'(ITER - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            bus.ready   <= 1'b1;
            bus.valid   <= 1'b0;
            bus.sel     <= '0;
            bus.dbz     <= 1'b0;
            bus.res_add <= '0;
            bus.res_sub <= '0;
            bus.res_mul <= '0;
            bus.res_div <= '0;
            op_q        <= OP_ADD;
            cnt         <= '0;
            prod        <= '0;
            mcand       <= '0;
            mplier      <= '0;
            rem         <= '0;
            quo         <= '0;
            divisor     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    bus.valid <= 1'b0;
                    if (bus.start) begin
                        bus.ready <= 1'b0;
                        bus.sel   <= sel_dec;
                        bus.dbz   <= 1'b0;
                        op_q      <= bus.op;
                        cnt       <= '0;
                        unique case (bus.op)
                            OP_ADD: begin
                                bus.res_add <= RW'(sum);
                                bus.valid   <= 1'b1;
                                state       <= S_DONE;
                            end
                            OP_SUB: begin
                                bus.res_sub <= {{(WIDTH-1){diff[WIDTH]}}, diff};
                                bus.valid   <= 1'b1;
                                state       <= S_DONE;
                            end
                            OP_MUL: begin
                                prod   <= '0;
                                mcand  <= RW'(bus.a);
                                mplier <= bus.b;
                                state  <= S_ITER;
                            end
                            OP_DIV: begin
                                if (bus.b == '0) begin
                                    bus.res_div <= {bus.a, {WIDTH{1'b1}}};
                                    bus.dbz     <= 1'b1;
                                    bus.valid   <= 1'b1;
                                    state       <= S_DONE;
                                end else begin
                                    rem     <= '0;
                                    quo     <= bus.a;
                                    divisor <= bus.b;
                                    state   <= S_ITER;
                                end
                            end
                        endcase
                    end
                end
                S_ITER: begin
                    cnt <= cnt + CW'(1);
                    if (op_q == OP_MUL) begin
                        prod   <= prod_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end else begin
                        rem <= rem_next;
                        quo <= quo_next;
                    end
                    // Only the final step is published to the result port.
                    if (last) begin
                        bus.valid <= 1'b1;
                        state     <= S_DONE;
                        if (op_q == OP_MUL) begin
                            bus.res_mul <= prod_next;
                        end else begin
                            bus.res_div <= {rem_next, quo_next};
                        end
                    end
                end
                S_DONE: begin
                    bus.valid <= 1'b0;
                    bus.ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_op_sequencer_if #(.WIDTH(8)) bus();

    alu_op_sequencer #(.WIDTH(8), .ITER(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      name, act, exp, $time);
    endtask

    // Reference model: per accepted op, a result value and a delay in edges
    logic        exp_ready = 1'b1;
    logic        exp_valid = 1'b0;
    logic [3:0]  exp_sel = 4'd0;
    logic        exp_dbz = 1'b0;
    logic [15:0] exp_res [4] = '{16'd0, 16'd0, 16'd0, 16'd0};
    int          cd = 0;
    bit          done_next = 1'b0;
    logic [1:0]  p_op = 2'd0;
    logic [15:0] p_val = 16'd0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_ready = 1'b1;
                exp_valid = 1'b0;
                exp_sel   = 4'd0;
                exp_dbz   = 1'b0;
                for (int k = 0; k < 4; k++) exp_res[k] = 16'd0;
                cd        = 0;
                done_next = 1'b0;
            end else begin
                exp_valid = 1'b0;
                if (done_next) begin
                    done_next = 1'b0;
                    exp_ready = 1'b1;
                end else if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        exp_res[p_op] = p_val;
                        exp_valid     = 1'b1;
                        done_next     = 1'b1;
                    end
                end else if (exp_ready && bus.start) begin
                    int ia;
                    int ib;
                    int v;
                    ia = int'(bus.a);
                    ib = int'(bus.b);
                    exp_ready = 1'b0;
                    exp_sel   = 4'(1 << bus.op);
                    exp_dbz   = (bus.op == 2'd3) && (ib == 0);
                    case (bus.op)
                        2'd0: v = ia + ib;
                        2'd1: v = ia - ib;
                        2'd2: v = ia * ib;
                        default: v = (ib == 0) ? (ia * 256 + 255)
                                               : ((ia % ib) * 256 + ia / ib);
                    endcase
                    p_op  = bus.op;
                    p_val = 16'(v);
                    if (bus.op == 2'd2 || (bus.op == 2'd3 && ib != 0)) begin
                        cd = 8;
                    end else begin
                        exp_res[p_op] = p_val;
                        exp_valid     = 1'b1;
                        done_next     = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("ready", 32'(bus.ready), 32'(exp_ready));
            chk("valid", 32'(bus.valid), 32'(exp_valid));
            chk("sel", 32'(bus.sel), 32'(exp_sel));
            chk("dbz", 32'(bus.dbz), 32'(exp_dbz));
            chk("res_add", 32'(bus.res_add), 32'(exp_res[0]));
            chk("res_sub", 32'(bus.res_sub), 32'(exp_res[1]));
            chk("res_mul", 32'(bus.res_mul), 32'(exp_res[2]));
            chk("res_div", 32'(bus.res_div), 32'(exp_res[3]));
        end
    end

    // Called at a negedge; returns cycles from acceptance to valid
    task automatic issue(input logic [1:0] o, input logic [7:0] x,
                         input logic [7:0] y, input int poke, output int lat);
        int n;
        n = 0;
        while (!bus.ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_start", 32'(bus.ready), 1);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        lat = 1;
        forever begin
            chk("busy_ready", 32'(bus.ready), 0);
            if (bus.valid || lat >= 30) break;
            @(negedge clk);
            lat++;
            bus.start = (lat == poke);
            bus.op    = 2'd0;
        end
        bus.start = 1'b0;
    endtask

    int lat;

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.a     = 8'd0;
        bus.b     = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 1);
        chk("rst_valid", 32'(bus.valid), 0);
        chk("rst_sel", 32'(bus.sel), 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(2'd0, 8'd200, 8'd100, -1, lat);
        chk("add_lat", 32'(lat), 1);
        chk("add_res", 32'(bus.res_add), 'h012C);
        chk("add_sel", 32'(bus.sel), 'h1);
        @(negedge clk);
        chk("add_ready_again", 32'(bus.ready), 1);

        issue(2'd1, 8'd5, 8'd10, -1, lat);
        chk("sub_lat", 32'(lat), 1);
        chk("sub_res", 32'(bus.res_sub), 'hFFFB);
        chk("sub_sel", 32'(bus.sel), 'h2);
        chk("sub_keeps_add", 32'(bus.res_add), 'h012C);
        @(negedge clk);

        issue(2'd2, 8'd255, 8'd255, 4, lat);
        chk("mul_lat", 32'(lat), 9);
        chk("mul_res", 32'(bus.res_mul), 'hFE01);
        chk("mul_sel", 32'(bus.sel), 'h4);
        chk("mul_keeps_add", 32'(bus.res_add), 'h012C);
        @(negedge clk);
        chk("mul_ready_again", 32'(bus.ready), 1);

        issue(2'd3, 8'd200, 8'd7, -1, lat);
        chk("div_lat", 32'(lat), 9);
        chk("div_res", 32'(bus.res_div), 'h041C);
        chk("div_dbz", 32'(bus.dbz), 0);
        @(negedge clk);

        issue(2'd3, 8'h55, 8'd0, -1, lat);
        chk("dbz_lat", 32'(lat), 1);
        chk("dbz_res", 32'(bus.res_div), 'h55FF);
        chk("dbz_flag", 32'(bus.dbz), 1);
        chk("dbz_sel", 32'(bus.sel), 'h8);
        @(negedge clk);
        chk("dbz_ready_again", 32'(bus.ready), 1);

        bus.start = 1'b1;
        bus.op    = 2'd2;
        bus.a     = 8'd16;
        bus.b     = 8'd16;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(bus.ready), 1);
        chk("abort_valid", 32'(bus.valid), 0);
        chk("abort_sel", 32'(bus.sel), 0);
        chk("abort_add", 32'(bus.res_add), 0);
        chk("abort_sub", 32'(bus.res_sub), 0);
        chk("abort_mul", 32'(bus.res_mul), 0);
        chk("abort_div", 32'(bus.res_div), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(bus.valid), 0);
        end

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (i % 500 == 250) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            bus.start = ($urandom_range(0, 2) == 0);
            bus.op    = 2'($urandom);
            case ($urandom_range(0, 5))
                0: bus.a = 8'hFF;
                1: bus.a = 8'h00;
                default: bus.a = 8'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: bus.b = 8'h00;
                1: bus.b = 8'hFF;
                2: bus.b = 8'h01;
                default: bus.b = 8'($urandom);
            endcase
        end
        bus.start = 1'b0;
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
